// File: rtl/video_mode_pkg.sv
// Shared FSM state, mode class type and default constants for the video mode detector.
package video_mode_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   typedef struct packed {
      logic rate_60;
      logic pass;
   } mode_t;

   localparam int DEF_CNT_W          = 22;
   localparam int DEF_LINE_W         = 11;
   localparam int DEF_SPLIT_PERIOD   = 1325893;
   localparam int DEF_MIN_PERIOD     = 742500;
   localparam int DEF_TIMEOUT_PERIOD = 2970000;
   localparam int DEF_VGA_LINES      = 400;
   localparam int DEF_LOCK_FRAMES    = 4;

endpackage

// File: rtl/sync_period_meter.sv
// Sync edge detector and frame meter: clk cycles and hsync edges per accepted vsync period.
// frame_vld/timeout are registered one clk after the registered sync edge; free-running, no backpressure.
module sync_period_meter
   import video_mode_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int LINE_W         = DEF_LINE_W,
   parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
   parameter int TIMEOUT_PERIOD = DEF_TIMEOUT_PERIOD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hsync,
   input  logic              vsync,
   output logic              frame_vld,
   output logic [CNT_W-1:0]  frame_period,
   output logic [LINE_W-1:0] frame_lines,
   output logic              timeout
);

   logic              hs_q, hs_prev, vs_q, vs_prev;
   logic [CNT_W-1:0]  period_cnt;
   logic [LINE_W-1:0] line_cnt;
   logic              hs_rise, vs_rise, accept;

   assign hs_rise = hs_q & ~hs_prev;
   assign vs_rise = vs_q & ~vs_prev;
   assign accept  = vs_rise && (period_cnt >= CNT_W'(MIN_PERIOD));

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q         <= 1'b0;
         hs_prev      <= 1'b0;
         vs_q         <= 1'b0;
         vs_prev      <= 1'b0;
         period_cnt   <= '0;
         line_cnt     <= '0;
         frame_vld    <= 1'b0;
         frame_period <= '0;
         frame_lines  <= '0;
         timeout      <= 1'b0;
      end else begin
         hs_q      <= hsync;
         hs_prev   <= hs_q;
         vs_q      <= vsync;
         vs_prev   <= vs_q;
         frame_vld <= accept;
         // Fires once per loss: the counter only passes this value on its way to saturation.
         timeout   <= ~accept && (period_cnt == CNT_W'(TIMEOUT_PERIOD));
         if (accept) begin
            frame_period <= period_cnt;
            frame_lines  <= line_cnt;
            period_cnt   <= CNT_W'(1);
            line_cnt     <= '0;
         end else begin
            if (period_cnt != '1)
               period_cnt <= period_cnt + CNT_W'(1);
            if (hs_rise && (line_cnt != '1))
               line_cnt <= line_cnt + LINE_W'(1);
         end
      end
   end

endmodule

// File: rtl/video_mode_detect.sv
// Classifies incoming video timing as 50/60 Hz and VGA/passthrough, committing a mode after repeated agreement.
// Outputs update two clk edges after vsync is first sampled high; no backpressure.
module video_mode_detect
   import video_mode_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int LINE_W         = DEF_LINE_W,
   parameter int SPLIT_PERIOD   = DEF_SPLIT_PERIOD,
   parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
   parameter int TIMEOUT_PERIOD = DEF_TIMEOUT_PERIOD,
   parameter int VGA_LINES      = DEF_VGA_LINES,
   parameter int LOCK_FRAMES    = DEF_LOCK_FRAMES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_hsync,
   input  logic              i_vsync,
   output logic              o_rate_60,
   output logic              o_passthrough,
   output logic              o_locked,
   output logic              o_mode_change,
   output logic [CNT_W-1:0]  o_frame_period,
   output logic [LINE_W-1:0] o_line_count
);

   localparam int MW = $clog2(LOCK_FRAMES + 1);

   logic              frame_vld, timeout;
   logic [CNT_W-1:0]  frame_period;
   logic [LINE_W-1:0] frame_lines;
   state_t            state_q, state_d;
   mode_t             cls, mode_q, cand_q, cand_d;
   logic [MW-1:0]     match_q, match_d, mis_q, mis_d;
   logic              commit, lock_d;

   sync_period_meter #(
      .CNT_W          (CNT_W),
      .LINE_W         (LINE_W),
      .MIN_PERIOD     (MIN_PERIOD),
      .TIMEOUT_PERIOD (TIMEOUT_PERIOD)
   ) u_meter (
      .clk          (clk),
      .reset        (reset),
      .hsync        (i_hsync),
      .vsync        (i_vsync),
      .frame_vld    (frame_vld),
      .frame_period (frame_period),
      .frame_lines  (frame_lines),
      .timeout      (timeout)
   );

   assign cls           = {frame_period < CNT_W'(SPLIT_PERIOD), frame_lines > LINE_W'(VGA_LINES)};
   assign o_rate_60     = mode_q.rate_60;
   assign o_passthrough = mode_q.pass;

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= SEARCH;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (timeout)
         state_d = SEARCH;
      else if (frame_vld) begin
         if (state_q == SEARCH)
            state_d = VERIFY;
         else if (commit)
            state_d = LOCKED;
      end
   end

   always_comb begin
      cand_d  = cand_q;
      match_d = match_q;
      mis_d   = mis_q;
      commit  = 1'b0;
      lock_d  = o_locked;
      if (timeout) begin
         match_d = '0;
         mis_d   = '0;
         lock_d  = 1'b0;
      end else if (frame_vld) begin
         case (state_q)
            SEARCH: match_d = '0;
            VERIFY: begin
               match_d = (cls == cand_q) ? match_q + MW'(1) : MW'(1);
               cand_d  = cls;
               if (match_d == MW'(LOCK_FRAMES)) begin
                  commit  = 1'b1;
                  lock_d  = 1'b1;
                  match_d = '0;
                  mis_d   = '0;
               end
            end
            LOCKED: begin
               // A single agreeing frame forgives any partial run of disagreeing ones.
               if (cls == mode_q)
                  mis_d = '0;
               else begin
                  mis_d  = (cls == cand_q) ? mis_q + MW'(1) : MW'(1);
                  cand_d = cls;
                  if (mis_d == MW'(LOCK_FRAMES)) begin
                     commit = 1'b1;
                     mis_d  = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q         <= '0;
         cand_q         <= '0;
         match_q        <= '0;
         mis_q          <= '0;
         o_locked       <= 1'b0;
         o_mode_change  <= 1'b0;
         o_frame_period <= '0;
         o_line_count   <= '0;
      end else begin
         cand_q        <= cand_d;
         match_q       <= match_d;
         mis_q         <= mis_d;
         o_locked      <= lock_d;
         o_mode_change <= commit && (cand_d != mode_q);
         if (commit)
            mode_q <= cand_d;
         if (frame_vld) begin
            o_frame_period <= frame_period;
            o_line_count   <= frame_lines;
         end
      end
   end

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed bench for video_mode_detect with small timing parameters and hand-computed expectations.
module tb_video_mode_detect;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_hsync, i_vsync;
   logic        o_rate_60, o_passthrough, o_locked, o_mode_change;
   logic [11:0] o_frame_period;
   logic [10:0] o_line_count;

   int n_chk = 0;
   int n_fail = 0;
   int pulse_cnt = 0;

   always #5 clk = ~clk;

   video_mode_detect #(
      .CNT_W          (12),
      .LINE_W         (11),
      .SPLIT_PERIOD   (1000),
      .MIN_PERIOD     (500),
      .TIMEOUT_PERIOD (2000),
      .VGA_LINES      (10),
      .LOCK_FRAMES    (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_hsync        (i_hsync),
      .i_vsync        (i_vsync),
      .o_rate_60      (o_rate_60),
      .o_passthrough  (o_passthrough),
      .o_locked       (o_locked),
      .o_mode_change  (o_mode_change),
      .o_frame_period (o_frame_period),
      .o_line_count   (o_line_count)
   );

   // Every cycle o_mode_change is high adds one, so a stretched pulse shows up as 2+.
   always @(negedge clk)
      if (o_mode_change) pulse_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_vsync = 1'b0;
         i_hsync = 1'b0;
      end
   endtask

   // One frame: vsync on cycle 0, 'lines' hsync pulses every 20 cycles from cycle 10,
   // optional extra vsync at cycle 100.
   task automatic frame(input int period, input int lines, input bit glitch);
      for (int c = 0; c < period; c++) begin
         @(negedge clk);
         i_vsync = (c == 0) || (glitch && c == 100);
         i_hsync = (c >= 10) && ((c - 10) % 20 == 0) && ((c - 10) / 20 < lines);
      end
   endtask

   task automatic chk_mode(input string tag, input logic lk, input logic r60, input logic ps);
      chk({tag, "_locked"}, o_locked, lk);
      chk({tag, "_rate60"}, o_rate_60, r60);
      chk({tag, "_pass"}, o_passthrough, ps);
   endtask

   initial begin
      reset   = 1'b1;
      i_hsync = 1'b0;
      i_vsync = 1'b0;
      repeat (3) @(negedge clk);
      chk_mode("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_change", o_mode_change, 0);
      chk("rst_period", o_frame_period, 0);
      chk("rst_lines", o_line_count, 0);
      reset = 1'b0;

      // Reach VERIFY (one restart edge + one matching edge), then reset mid-verify.
      idle(600);
      frame(1200, 5, 1'b0);
      frame(1200, 5, 1'b0);
      chk("pre_rst_period", o_frame_period, 1200);
      chk("pre_rst_locked", o_locked, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_mode("mid_rst", 1'b0, 1'b0, 1'b0);
      chk("mid_rst_period", o_frame_period, 0);
      chk("mid_rst_lines", o_line_count, 0);

      // 1200-cycle / 5-line frames lock on the 4th edge as 50 Hz, VGA.
      idle(600);
      repeat (3) frame(1200, 5, 1'b0);
      chk("edge3_locked", o_locked, 0);
      frame(1200, 5, 1'b0);
      chk_mode("lock50", 1'b1, 1'b0, 1'b0);
      chk("lock50_period", o_frame_period, 1200);
      chk("lock50_lines", o_line_count, 5);
      chk("lock50_pulses", pulse_cnt, 0);

      // Glitch 100 cycles into a frame, then isolated 900 frames between 1200 frames.
      frame(1200, 5, 1'b1);
      frame(900, 5, 1'b0);
      chk("glitch_period", o_frame_period, 1200);
      chk("glitch_lines", o_line_count, 5);
      frame(1200, 5, 1'b0);
      chk("single900_period", o_frame_period, 900);
      frame(900, 5, 1'b0);
      frame(1200, 5, 1'b0);
      frame(900, 5, 1'b0);
      frame(1200, 5, 1'b0);
      frame(1200, 5, 1'b0);
      chk_mode("isolated", 1'b1, 1'b0, 1'b0);
      chk("isolated_pulses", pulse_cnt, 0);

      // Sustained 900-cycle / 12-line frames commit on the 3rd disagreeing frame.
      repeat (3) frame(900, 12, 1'b0);
      chk_mode("sw2", 1'b1, 1'b0, 1'b0);
      chk("sw2_period", o_frame_period, 900);
      chk("sw2_lines", o_line_count, 12);
      frame(900, 12, 1'b0);
      chk_mode("sw3", 1'b1, 1'b1, 1'b1);
      chk("sw3_pulses", pulse_cnt, 1);

      // vsync stops: last edge drove cycle 0 of the frame above, 899 cycles ago.
      idle(1103);
      chk("tmo_before", o_locked, 1);
      idle(1);
      chk_mode("tmo", 1'b0, 1'b1, 1'b1);

      // Resume: one restart edge plus three agreeing edges.
      repeat (3) frame(900, 12, 1'b0);
      chk("resume3_locked", o_locked, 0);
      frame(900, 12, 1'b0);
      chk_mode("relock", 1'b1, 1'b1, 1'b1);
      chk("relock_pulses", pulse_cnt, 1);
      chk("relock_period", o_frame_period, 900);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/video_mode_detect.md
VIDEO_MODE_DETECT -- requirements
Module: video_mode_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 22: frame-period counter width in bits.
REQ-002 SHALL have parameter LINE_W, default 11: line counter width in bits.
REQ-003 SHALL have parameter SPLIT_PERIOD, default 1325893: period threshold in clk cycles (56 Hz at 74.25 MHz); a period >= SPLIT_PERIOD is 50 Hz class, otherwise 60 Hz class.
REQ-004 SHALL have parameter MIN_PERIOD, default 742500: a vsync edge arriving earlier than this is a glitch.
REQ-005 SHALL have parameter TIMEOUT_PERIOD, default 2970000: no vsync within this many cycles means signal loss.
REQ-006 SHALL have parameter VGA_LINES, default 400: a line count strictly above this selects passthrough.
REQ-007 SHALL have parameter LOCK_FRAMES, default 4: number of consecutive agreeing frames needed to commit a mode.
REQ-008 SHALL have port clk, input, width 1: the single clock; all logic is on the rising edge.
REQ-009 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-010 SHALL have port i_hsync, input, width 1: line sync, already synchronous to clk, active-high.
REQ-011 SHALL have port i_vsync, input, width 1: frame sync, already synchronous to clk, active-high.
REQ-012 SHALL have port o_rate_60, output, width 1: committed rate class (0 = 50 Hz, 1 = 60 Hz).
REQ-013 SHALL have port o_passthrough, output, width 1: committed source-clock passthrough select.
REQ-014 SHALL have port o_locked, output, width 1: committed mode is valid.
REQ-015 SHALL have port o_mode_change, output, width 1: one-cycle pulse when a commit changes o_rate_60 or o_passthrough.
REQ-016 SHALL have port o_frame_period, output, width CNT_W: last accepted frame period.
REQ-017 SHALL have port o_line_count, output, width LINE_W: last accepted lines per frame.

Function
REQ-018 SHALL register i_hsync and i_vsync once and detect rising edges as (current high AND previous low).
REQ-019 The period counter SHALL increment every cycle and saturate at 2^CNT_W-1.
REQ-020 The line counter SHALL increment on each hsync rising edge and saturate at 2^LINE_W-1.
REQ-021 On a vsync edge with period >= MIN_PERIOD, the block SHALL capture both counters, reload the period counter to 1 and the line counter to 0, and drop any hsync edge in the same cycle.
REQ-022 A vsync edge with period < MIN_PERIOD SHALL be ignored: no capture, no counter reload, no FSM step.
REQ-023 Classification of each accepted frame SHALL be: rate60 = (period < SPLIT_PERIOD); pass = (lines > VGA_LINES).
REQ-024 The FSM SHALL have three states, SEARCH, VERIFY and LOCKED, and SHALL enter SEARCH after reset.
REQ-025 In SEARCH, the first vsync edge SHALL only restart the counters (no classification), then the FSM SHALL enter VERIFY with match_cnt = 0.
REQ-026 In VERIFY, on each accepted edge: if the class equals the stored candidate then match_cnt++, else the candidate is replaced and match_cnt = 1.
REQ-027 In VERIFY, when match_cnt reaches LOCK_FRAMES the block SHALL commit the candidate, set o_locked = 1 and enter LOCKED.
REQ-028 In LOCKED, a class equal to the committed class SHALL clear mis_cnt.
REQ-029 In LOCKED, a differing class SHALL apply the same candidate/count rule as VERIFY on mis_cnt; at LOCK_FRAMES the block SHALL commit the new class and remain in LOCKED.
REQ-030 o_mode_change SHALL pulse for exactly one cycle on any commit whose value differs from the prior outputs, including the first lock when the class differs from the reset value.
REQ-031 When the period counter reaches TIMEOUT_PERIOD, from any state, the FSM SHALL go to SEARCH, drop o_locked to 0, clear match_cnt and mis_cnt, and hold o_rate_60 and o_passthrough.
REQ-032 Outputs SHALL update on the second rising clk edge after the edge at which i_vsync is first sampled high.
REQ-033 o_frame_period and o_line_count SHALL update on every accepted edge, in any state.

Reset
REQ-034 With reset high at a clk edge, all outputs, counters, candidates and sync registers SHALL clear to 0 and the FSM SHALL be in SEARCH from the next cycle, regardless of operation in progress.

Structure
REQ-035 Package video_mode_pkg SHALL hold the FSM state typedef and the default parameter constants.
REQ-036 Sub-module sync_period_meter SHALL own edge detection, the period and line counters, glitch rejection and timeout; the FSM and commit logic SHALL live in the top level.

Verification (bench parameters: CNT_W=12, SPLIT=1000, MIN=500, TIMEOUT=2000, VGA_LINES=10, LOCK_FRAMES=3)
REQ-037 Frames of 1200 cycles with 5 lines -> after the 4th vsync edge: o_locked=1, o_rate_60=0, o_passthrough=0, o_frame_period=1200, o_line_count=5, no change pulse.
REQ-038 After lock, switch to 900-cycle frames with 12 lines -> outputs unchanged for 2 frames; on the 3rd: o_rate_60=1, o_passthrough=1, one single-cycle o_mode_change.
REQ-039 While locked at 1200, insert one 900 frame then resume 1200 -> no commit, no pulse, o_locked stays 1.
REQ-040 Extra vsync pulse 100 cycles after a valid edge -> ignored; next o_frame_period=1200.
REQ-041 vsync stops -> o_locked=0 exactly 2000 cycles after the last edge; on resume, relock after 1 + 3 edges.
REQ-042 Reset pulsed mid-VERIFY -> all outputs 0 on the next cycle; relock follows the REQ-037 sequence.
